// File: rtl/rca_word_seq.sv
// rca_word_seq
//   Multi-word add/subtract sequencer around an external 3-bit ripple-carry
//   adder stage. A wide operand pair is accepted over a valid/ready handshake,
//   then fed to the adder one 3-bit slice per cycle (LSB slice first). The
//   adder's carry-out is chained into the next slice. The assembled result and
//   the final carry are presented over a valid/ready handshake.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready high only in IDLE)
//   op_a, op_b        : W-bit operands, W = 3*WORDS
//   op_cin            : carry-in for add; ignored when op_sub=1
//   op_sub            : 1 = A - B, 0 = A + B + op_cin
//   rca_a/rca_b/rca_cin : slice drive to the external adder (0 outside RUN)
//   rca_sum/rca_cout  : external adder outputs
//   out_valid/out_ready : result handshake
//   result, result_cout : W-bit result and final carry (1 = no borrow on sub)
//   busy              : high in RUN or DONE
module rca_word_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*WORDS-1:0]   op_a,
  input  logic [3*WORDS-1:0]   op_b,
  input  logic                 op_cin,
  input  logic                 op_sub,
  output logic [2:0]           rca_a,
  output logic [2:0]           rca_b,
  output logic                 rca_cin,
  input  logic [2:0]           rca_sum,
  input  logic                 rca_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WORDS-1:0]   result,
  output logic                 result_cout,
  output logic                 busy
);

  localparam int unsigned W  = 3 * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  res_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;
  logic [2:0]    a_slice;
  logic [2:0]    b_slice;

  // Slice select written as a decoded mux so every part-select is constant.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        a_slice = a_reg[3*w +: 3];
        b_slice = b_reg[3*w +: 3];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    rca_a       = '0;
    rca_b       = '0;
    rca_cin     = 1'b0;
    result      = res_reg;
    result_cout = carry_reg;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        busy    = 1'b1;
        rca_a   = a_slice;
        rca_b   = b_slice;
        rca_cin = carry_reg;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            // Subtract as A + ~B + 1: invert B here and seed the carry with 1.
            b_reg     <= op_sub ? ~op_b : op_b;
            carry_reg <= op_sub ? 1'b1 : op_cin;
            idx       <= '0;
            res_reg   <= '0;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) res_reg[3*w +: 3] <= rca_sum;
          end
          carry_reg <= rca_cout;
          if (idx != LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_word_seq.sv
module tb_rca_word_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 3 * WORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          op_cin = 1'b0;
  logic          op_sub = 1'b0;
  logic [2:0]    rca_a;
  logic [2:0]    rca_b;
  logic          rca_cin;
  logic [2:0]    rca_sum;
  logic          rca_cout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          result_cout;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;
  logic [W:0] sb[$];

  rca_word_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_sum(rca_sum), .rca_cout(rca_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .busy(busy)
  );

  // External 3-bit ripple-carry stage.
  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {3'b000, rca_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {carry, result}.
  function automatic logic [W:0] ref_model(input int a, input int b, input bit cin, input bit sub);
    int m;
    int s;
    m = 1 << W;
    if (sub) begin
      s = ((a - b) % m + m) % m;
      return {(a >= b) ? 1'b1 : 1'b0, W'(s)};
    end
    s = a + b + int'(cin);
    return {(s >= m) ? 1'b1 : 1'b0, W'(s % m)};
  endfunction

  // Monitor: every completed output handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e[W-1:0]));
        chk("result_cout", 32'(result_cout), 32'(e[W]));
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Caller is at posedge+#1. Returns at posedge+#1 after the accept edge.
  task automatic send(input int a, input int b, input bit cin, input bit sub);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op_a = W'(a); op_b = W'(b); op_cin = cin; op_sub = sub;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) sb.push_back(ref_model(a, b, cin, sub));
    else chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int a, b, cin_k;
    logic [W:0] e;

    // Reset state.
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(result_cout), 32'd0);
    chk("rst_rca", 32'({rca_a, rca_b, rca_cin}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 0x123 + 0x456: per-slice adder drive and latency.
    a = 'h123; b = 'h456;
    send(a, b, 1'b0, 1'b0);
    for (int k = 0; k < int'(WORDS); k++) begin
      if (k == 0) cin_k = 0;
      else cin_k = ((a % (1 << (3*k))) + (b % (1 << (3*k)))) >> (3*k);
      chk($sformatf("rca_a_%0d", k), 32'(rca_a), 32'((a >> (3*k)) & 7));
      chk($sformatf("rca_b_%0d", k), 32'(rca_b), 32'((b >> (3*k)) & 7));
      chk($sformatf("rca_cin_%0d", k), 32'(rca_cin), 32'(cin_k));
      chk($sformatf("early_valid_%0d", k), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("done_rca", 32'({rca_a, rca_b, rca_cin}), 32'd0);
    drain();

    // Carry/borrow boundaries; op_cin=1 is ignored on subtract.
    send('hFFF, 'h001, 1'b0, 1'b0);
    send('h000, 'h000, 1'b1, 1'b0);
    send('hFFF, 'hFFF, 1'b1, 1'b0);
    send('h100, 'h001, 1'b1, 1'b1);
    send('h000, 'h001, 1'b1, 1'b1);
    drain();

    // Backpressure in DONE with a new operand pair offered.
    out_ready = 1'b0;
    send('h5A5, 'h0F0, 1'b0, 1'b1);
    e = ref_model('h5A5, 'h0F0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    in_valid = 1'b1; op_a = W'('h321); op_b = W'('h123); op_cin = 1'b0; op_sub = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'(e[W-1:0]));
      chk("bp_cout", 32'(result_cout), 32'(e[W]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    sb.push_back(ref_model('h321, 'h123, 1'b0, 1'b0));
    @(posedge clk); #1;
    chk("bp_next_taken", 32'(busy), 32'd1);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN (idx=2).
    in_valid = 1'b1; op_a = W'('hABC); op_b = W'('h777); op_cin = 1'b1; op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_rca", 32'({rca_a, rca_b, rca_cin}), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send('h007, 'h001, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random output stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin @(posedge clk); #1; end
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
